// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state enum, slot count and slot index type for the TDM receiver
package tdm_pkg;
    localparam int TDM_SLOTS = 8;
    localparam int TDM_SEL_W = $clog2(TDM_SLOTS);
    typedef logic [TDM_SEL_W-1:0] slot_t;
    typedef enum logic {HUNT, COLLECT} state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: wrapping slot counter with synchronous clear, load-to-1 and last-slot flag
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int SEL_W = TDM_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    output logic [SEL_W-1:0] cnt,
    output logic             last
);
    logic [SEL_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : load ? SEL_W'(1) : inc ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cnt  = cnt_q;
    assign last = cnt_q == '1;
endmodule

// File: rtl/tdm_demux_8to1.sv
// tdm_demux_8to1: rebuilds WIDTH-bit words from a sof-aligned serial stream; TDM_SEL_CHECK_EN adds a far-end sel slot check
module tdm_demux_8to1
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_SLOTS,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
`ifdef TDM_SEL_CHECK_EN
    input  logic [SEL_W-1:0] sel,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d, dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d, frame_err_q, frame_err_d;
    logic [SEL_W-1:0] cnt;
    logic             last, cnt_clr, cnt_load, cnt_inc, sel_zero, sel_bad;
`ifdef TDM_SEL_CHECK_EN
    assign sel_zero = sel == '0;
    assign sel_bad  = sel != cnt;
`else
    assign sel_zero = 1'b1;
    assign sel_bad  = 1'b0;
`endif
    tdm_slot_counter #(.SEL_W(SEL_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .load (cnt_load),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .last (last)
    );
    // An accepted sof always restarts at slot 0; it is an error only if a frame was in progress.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;
        if (din_valid) begin
            if (sof && sel_zero) begin
                shadow_d[0] = din;
                cnt_load    = 1'b1;
                state_d     = COLLECT;
                frame_err_d = state_q == COLLECT && cnt != '0;
            end else if (state_q == COLLECT) begin
                if (sel_bad) begin
                    frame_err_d = 1'b1;
                    cnt_clr     = 1'b1;
                    state_d     = HUNT;
                end else begin
                    shadow_d[cnt] = din;
                    cnt_inc       = 1'b1;
                    if (last) begin
                        dout_d       = {din, shadow_q[WIDTH-2:0]};
                        dout_valid_d = 1'b1;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_tdm_demux_8to1.sv
// tb_tdm_demux_8to1: randomized scoreboard bench for tdm_demux_8to1 (TDM_SEL_CHECK_EN selects the sel-check variant)
module tb_tdm_demux_8to1;
    localparam int W = 8;
`ifdef TDM_SEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    typedef struct {
        bit           err;
        logic [W-1:0] word;
        int           cyc;
    } ev_t;

    logic         clk = 1'b0, rst_n = 1'b0, din = 1'b0, din_valid = 1'b0, sof = 1'b0;
    logic [2:0]   sel = '0;
    logic [W-1:0] dout;
    logic         dout_valid, frame_err;
    int           cyc = 0, total = 0, bad = 0;
    bit           rst_edge = 1'b0, aligned = 1'b0;
    bit           cur[$];
    ev_t          q[$];
    logic [W-1:0] exp_dout = '0;

    tdm_demux_8to1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sof       (sof),
`ifdef TDM_SEL_CHECK_EN
        .sel       (sel),
`endif
        .dout      (dout),
        .dout_valid(dout_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_edge = !rst_n;
    end

    // Frame-level reference: bits collected per frame in a queue; expected pulses land one cycle after the bit.
    task automatic model(input bit b, input bit s, input int sl);
        ev_t e;
        if (s && (!CHK || sl == 0)) begin
            if (cur.size() != 0) begin
                e.err = 1'b1; e.word = '0; e.cyc = cyc + 1; q.push_back(e);
            end
            cur.delete();
            aligned = 1'b1;
            cur.push_back(b);
        end else if (aligned) begin
            if (CHK && sl != cur.size()) begin
                e.err = 1'b1; e.word = '0; e.cyc = cyc + 1; q.push_back(e);
                aligned = 1'b0;
                cur.delete();
            end else cur.push_back(b);
        end
        if (cur.size() == W) begin
            e.err = 1'b0;
            e.word = '0;
            foreach (cur[i]) e.word[i] = cur[i];
            e.cyc = cyc + 1;
            q.push_back(e);
            cur.delete();
        end
    endtask

    task automatic send_bit(input bit b, input bit s, input int sl);
        @(posedge clk); #1;
        rst_n = 1'b1; din_valid = 1'b1; din = b; sof = s; sel = 3'(sl);
        model(b, s, sl);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        rst_n = 1'b1; din_valid = 1'b0; din = 1'($urandom); sof = 1'($urandom); sel = 3'($urandom);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rst_n = 1'b0; din_valid = 1'($urandom); din = 1'($urandom); sof = 1'($urandom);
        end
        cur.delete();
        aligned = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int n, input bit s, input bit stalls);
        for (int i = 0; i < n; i++) begin
            if (stalls && $urandom_range(0, 3) == 0) idle();
            send_bit(w[i], s && i == 0, i);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_edge) begin
            exp_dout = '0;
            total++;
            if (dout !== '0 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
                bad++;
                $display("FAIL reset: dout=%h valid=%b err=%b, want 00/0/0", dout, dout_valid, frame_err);
            end
        end else begin
            while (q.size() != 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                total++; bad++;
                $display("FAIL missed_pulse: err=%b word=%h due cycle %0d not seen", e.err, e.word, e.cyc);
            end
            if (dout_valid === 1'b1 || frame_err === 1'b1) begin
                total++;
                if (dout_valid === 1'b1 && frame_err === 1'b1) begin
                    bad++;
                    $display("FAIL both_pulses: valid and err high together at cycle %0d", cyc);
                end else if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: valid=%b err=%b dout=%h at cycle %0d, want none", dout_valid, frame_err, dout, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.err != frame_err || e.cyc != cyc) begin
                        bad++;
                        $display("FAIL pulse: err=%b cycle=%0d, want err=%b cycle=%0d", frame_err, cyc, e.err, e.cyc);
                    end
                    if (!e.err) exp_dout = e.word;
                end
            end
            total++;
            if (dout !== exp_dout) begin
                bad++;
                $display("FAIL dout: got %h, want %h at cycle %0d", dout, exp_dout, cyc);
            end
        end
    end

    initial begin
        int p;
        logic [W-1:0] w;
        do_reset(2);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0, $urandom_range(0, 7));
        send_word(8'h8A, W, 1'b1, 1'b0);
        p = $urandom_range(1, 7);
        w = 8'h5C;
        for (int i = 0; i < W; i++) begin
            if (i == p) repeat (3) idle();
            send_bit(w[i], 1'b0, i);
        end
        send_word(W'($urandom), 4, 1'b1, 1'b0);
        send_word(8'hFF, W, 1'b1, 1'b0);
        send_word(W'($urandom), 6, 1'b1, 1'b0);
        do_reset(1);
        send_word(8'h01, W, 1'b1, 1'b0);
        send_word(W'($urandom), 7, 1'b1, 1'b0);
        send_word(8'hA5, W, 1'b1, 1'b0);
`ifdef TDM_SEL_CHECK_EN
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 1);
        send_bit(1'b1, 1'b0, 2);
        send_bit(1'b1, 1'b0, 4);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b1, 3);
        send_word(8'h3C, W, 1'b1, 1'b0);
`endif
        for (int k = 0; k < 60; k++) begin
            p = $urandom_range(0, 9);
            w = W'($urandom);
            if (p == 0) send_word(w, $urandom_range(1, 7), 1'b1, 1'b1);
            else if (p == 1 && CHK) begin
                int j = $urandom_range(0, W - 1);
                for (int i = 0; i < W; i++) send_bit(w[i], i == 0, i == j ? (i + 1) % W : i);
            end else if (p == 2) do_reset($urandom_range(1, 2));
            else send_word(w, W, 1'($urandom), 1'b1);
        end
        repeat (4) idle();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending: %0d expected pulses never seen, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
